// File: rtl/led_demux_sequencer.sv
// LED demux pattern sequencer: debounced mode/pause switches,
// tick-divided stepping of steady, chase, bounce and alternate patterns.
module led_demux_sequencer #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int TICK_DIV       = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Tick,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  output logic       o_Data,
  output logic       o_Select_0,
  output logic       o_Select_1,
  output logic [1:0] o_Mode,
  output logic       o_Running
);

  localparam int DW = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_LIMIT);
  localparam logic [TW-1:0] TK_MAX = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    STEADY    = 2'd0,
    CHASE     = 2'd1,
    BOUNCE    = 2'd2,
    ALTERNATE = 2'd3
  } mode_e;

  // Bit 0 is the mode switch, bit 1 the run/pause switch.
  logic [1:0]    raw;
  logic [1:0]    meta_q;
  logic [1:0]    sync_q;
  logic [1:0]    stable_q;
  logic [1:0]    press_q;
  logic [DW-1:0] cnt_q [2];

  mode_e         mode_q;
  mode_e         mode_nx;
  logic [1:0]    ch_q;
  logic          down_q;
  logic          data_q;
  logic          run_q;
  logic [TW-1:0] tcnt_q;

  logic          mode_press;
  logic          run_press;

  assign raw        = {i_Switch_2, i_Switch_1};
  assign mode_press = press_q[0];
  assign run_press  = press_q[1];

  // Next mode in the 0->1->2->3->0 cycle.
  always_comb begin
    mode_nx = mode_e'(mode_q + 2'd1);
  end

  // Synchronise, debounce and edge-detect both switches.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      meta_q  <= raw;
      sync_q  <= meta_q;
      press_q <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_MAX) begin
          stable_q[i] <= sync_q[i];
          press_q[i]  <= sync_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Pattern state machine; a mode press overrides any step due.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mode_q <= STEADY;
      ch_q   <= 2'd0;
      down_q <= 1'b0;
      data_q <= 1'b0;
      run_q  <= 1'b1;
      tcnt_q <= '0;
    end else begin
      if (run_press) begin
        run_q <= ~run_q;
      end
      if (mode_press) begin
        mode_q <= mode_nx;
        ch_q   <= 2'd0;
        down_q <= 1'b0;
        tcnt_q <= '0;
        data_q <= (mode_nx == CHASE) || (mode_nx == BOUNCE);
      end else if (run_q && i_Tick) begin
        if (tcnt_q == TK_MAX) begin
          tcnt_q <= '0;
          unique case (mode_q)
            STEADY: begin
              data_q <= ~data_q;
            end
            CHASE: begin
              ch_q   <= ch_q + 2'd1;
              data_q <= 1'b1;
            end
            BOUNCE: begin
              data_q <= 1'b1;
              if (!down_q) begin
                if (ch_q == 2'd3) begin
                  down_q <= 1'b1;
                  ch_q   <= 2'd2;
                end else begin
                  ch_q <= ch_q + 2'd1;
                end
              end else begin
                if (ch_q == 2'd0) begin
                  down_q <= 1'b0;
                  ch_q   <= 2'd1;
                end else begin
                  ch_q <= ch_q - 2'd1;
                end
              end
            end
            ALTERNATE: begin
              if (data_q) begin
                data_q <= 1'b0;
                ch_q   <= ch_q + 2'd1;
              end else begin
                data_q <= 1'b1;
              end
            end
            default: begin
              data_q <= data_q;
            end
          endcase
        end else begin
          tcnt_q <= tcnt_q + 1'b1;
        end
      end
    end
  end

  assign o_Data     = data_q;
  assign o_Select_0 = ch_q[0];
  assign o_Select_1 = ch_q[1];
  assign o_Mode     = mode_q;
  assign o_Running  = run_q;

endmodule

// File: tb/tb_led_demux_sequencer.sv
// Directed bench for led_demux_sequencer: two instances
// (TICK_DIV 1 and 2) share stimulus; expected values are hand-derived.
module tb_led_demux_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic sw1;
  logic sw2;

  logic       a_data, a_s0, a_s1, a_run;
  logic [1:0] a_mode;
  logic       b_data, b_s0, b_s1, b_run;
  logic [1:0] b_mode;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_demux_sequencer #(.DEBOUNCE_LIMIT(4), .TICK_DIV(1)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Tick(tick),
    .i_Switch_1(sw1), .i_Switch_2(sw2),
    .o_Data(a_data), .o_Select_0(a_s0), .o_Select_1(a_s1),
    .o_Mode(a_mode), .o_Running(a_run)
  );

  led_demux_sequencer #(.DEBOUNCE_LIMIT(4), .TICK_DIV(2)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Tick(tick),
    .i_Switch_1(sw1), .i_Switch_2(sw2),
    .o_Data(b_data), .o_Select_0(b_s0), .o_Select_1(b_s1),
    .o_Mode(b_mode), .o_Running(b_run)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic d,
                       input logic [1:0] s, input logic [1:0] m,
                       input logic r);
    chk(tag, {3'b0, a_data, a_s1, a_s0, a_mode[1], a_mode[0]},
        {3'b0, d, s, m});
    chk({tag, "_run"}, {7'b0, a_run}, {7'b0, r});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic press1();
    sw1 = 1'b1;
    cyc(10);
    sw1 = 1'b0;
    cyc(10);
  endtask

  task automatic press2();
    sw2 = 1'b1;
    cyc(10);
    sw2 = 1'b0;
    cyc(10);
  endtask

  logic [1:0] bounce_exp [8];
  logic [1:0] alt_exp    [8];

  initial begin
    bounce_exp = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
    // {data, ch[0]} is enough? no: store data and ch separately below
    alt_exp    = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

    rst  = 1'b1;
    tick = 1'b0;
    sw1  = 1'b0;
    sw2  = 1'b0;
    cyc(3);
    chk_a("rst_hold", 1'b0, 2'd0, 2'd0, 1'b1);
    rst = 1'b0;
    cyc(3);
    chk_a("rst_rel", 1'b0, 2'd0, 2'd0, 1'b1);

    // STEADY: data toggles, select stays 0
    pulse_tick();
    chk_a("steady1", 1'b1, 2'd0, 2'd0, 1'b1);
    pulse_tick();
    chk_a("steady2", 1'b0, 2'd0, 2'd0, 1'b1);
    pulse_tick();
    chk_a("steady3", 1'b1, 2'd0, 2'd0, 1'b1);

    // CHASE
    press1();
    chk_a("chase_entry", 1'b1, 2'd0, 2'd1, 1'b1);
    chk("b_mode1", {6'b0, b_mode}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      pulse_tick();
      chk($sformatf("chase%0d", i), {6'b0, a_s1, a_s0},
          {6'b0, 2'(i + 1)});
    end

    // BOUNCE
    press1();
    chk_a("bounce_entry", 1'b1, 2'd0, 2'd2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      pulse_tick();
      chk($sformatf("bounce%0d", i), {6'b0, a_s1, a_s0},
          {6'b0, bounce_exp[i]});
    end

    // ALTERNATE on the TICK_DIV=2 instance
    press1();
    chk("b_alt_mode", {6'b0, b_mode}, 8'd3);
    chk("b_alt_entry", {6'b0, b_data, b_s1 | b_s0}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      logic ed;
      pulse_tick();
      // data after tick i+1: 0,1,1,0,0,1,1,0
      ed = (i == 1) || (i == 2) || (i == 5) || (i == 6);
      chk($sformatf("alt%0d", i), {5'b0, b_data, b_s1, b_s0},
          {5'b0, ed, alt_exp[i]});
    end
    // TICK_DIV=1 instance took 8 steps from (0,0): ends at (0,0)
    chk_a("a_alt8", 1'b0, 2'd0, 2'd3, 1'b1);
    pulse_tick();
    chk_a("a_alt9", 1'b1, 2'd0, 2'd3, 1'b1);

    // Short glitch on switch 2 is ignored
    sw2 = 1'b1;
    cyc(3);
    sw2 = 1'b0;
    cyc(12);
    chk_a("glitch", 1'b1, 2'd0, 2'd3, 1'b1);

    // Pause freezes outputs
    press2();
    chk_a("paused", 1'b1, 2'd0, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) pulse_tick();
    chk_a("frozen", 1'b1, 2'd0, 2'd3, 1'b0);
    press2();
    chk_a("resumed", 1'b1, 2'd0, 2'd3, 1'b1);
    pulse_tick();
    chk_a("resume_step", 1'b0, 2'd1, 2'd3, 1'b1);

    // Mode press in the same cycle as a due tick: press wins
    sw1 = 1'b1;
    cyc(7);
    chk_a("pre_collide", 1'b0, 2'd1, 2'd3, 1'b1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk_a("collide", 1'b0, 2'd0, 2'd0, 1'b1);
    sw1 = 1'b0;
    cyc(10);

    // Reset mid-CHASE with ch=2 while paused
    press1();
    pulse_tick();
    pulse_tick();
    chk_a("chase_ch2", 1'b1, 2'd2, 2'd1, 1'b1);
    press2();
    chk_a("chase_pause", 1'b1, 2'd2, 2'd1, 1'b0);
    rst = 1'b1;
    #1;
    chk_a("async_rst", 1'b0, 2'd0, 2'd0, 1'b1);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    pulse_tick();
    chk_a("post_rst", 1'b1, 2'd0, 2'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
